// File: rtl/binom_feeder.sv
// binom_feeder: repacks a 32-bit random word stream into k-bit binomial sampler operand pairs
// Ports: clk, rst_n (async active-low); start_i/mode_i/len_i set up a job of len_i beats with k from mode_i;
// rnd_data_i/rnd_valid_i/rnd_ready_o random word input; in_1_o/in_2_o/out_valid_o/out_ready_i operand beats;
// busy_o high while running, done_o one-cycle completion pulse.
// Optional macro BINOM_FEED_STATS_EN adds rnd_words_o, a saturating per-job count of accepted words.
module binom_feeder #(
  parameter int MAX_BEATS = 256,
  parameter int BUF_W = 64,
  localparam int LW = $clog2(MAX_BEATS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [2:0]    mode_i,
  input  logic [LW-1:0] len_i,
  input  logic [31:0]   rnd_data_i,
  input  logic          rnd_valid_i,
  output logic          rnd_ready_o,
  output logic [31:0]   in_1_o,
  output logic [31:0]   in_2_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o
`ifdef BINOM_FEED_STATS_EN
  , output logic [15:0] rnd_words_o
`endif
);
  localparam int CW = $clog2(BUF_W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] k_q, k_d, k_sel;
  logic [LW-1:0] beats_q, beats_d;
  logic [13:0] need_q, need_d;
  logic [CW-1:0] cnt_q, cnt_d, base, k4;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [15:0] m, f0, f1, f2, f3;
  logic accept, pop;
  assign k_sel = mode_i == 3'd0 ? 4'd2 : mode_i == 3'd1 ? 4'd3 : mode_i == 3'd2 ? 4'd4 :
                 mode_i == 3'd3 ? 4'd5 : 4'd8;
  assign k4 = CW'({k_q, 2'b00});
  assign rnd_ready_o = state_q == RUN && cnt_q <= CW'(32) && need_q != '0;
  assign out_valid_o = state_q == RUN && cnt_q >= k4 && beats_q != '0;
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign accept = rnd_valid_i && rnd_ready_o;
  assign pop = out_valid_o && out_ready_i;
  // four consecutive k-bit fields from the bottom of the buffer; 3k is taken as 4k-k
  assign m = ~(16'hFFFF << k_q);
  assign f0 = buf_q[15:0] & m;
  assign f1 = 16'(buf_q >> k_q) & m;
  assign f2 = 16'(buf_q >> {k_q, 1'b0}) & m;
  assign f3 = 16'(buf_q >> (k4 - CW'(k_q))) & m;
  assign in_1_o = {f2, f0};
  assign in_2_o = {f3, f1};
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    beats_d = beats_q;
    need_d = need_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    base = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        k_d = k_sel;
        beats_d = len_i;
        need_d = 14'(len_i) * 14'({k_sel, 2'b00});
        cnt_d = '0;
        buf_d = '0;
        state_d = len_i == '0 ? DONE : RUN;
      end
      RUN: begin
        // on a simultaneous pop the new word lands just above the bits that remain after the shift
        base = pop ? cnt_q - k4 : cnt_q;
        buf_d = (pop ? buf_q >> k4 : buf_q) | (accept ? BUF_W'(rnd_data_i) << base : '0);
        cnt_d = base + (accept ? CW'(32) : CW'(0));
        need_d = accept ? need_q - (need_q > 14'd32 ? 14'd32 : need_q) : need_q;
        beats_d = beats_q - LW'(pop);
        state_d = pop && beats_q == LW'(1) ? DONE : RUN;
      end
      DONE: begin
        buf_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      beats_q <= '0;
      need_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      beats_q <= beats_d;
      need_q <= need_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
`ifdef BINOM_FEED_STATS_EN
  logic [15:0] words_q, words_d;
  assign words_d = state_q == IDLE && start_i ? 16'd0 :
                   accept && words_q != 16'hFFFF ? words_q + 16'd1 : words_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) words_q <= '0;
    else words_q <= words_d;
  assign rnd_words_o = words_q;
`endif
endmodule

// File: tb/tb_binom_feeder.sv
// tb_binom_feeder: randomized scoreboard bench for binom_feeder against a bit-stream model
module tb_binom_feeder;
  logic clk = 0, rst_n = 0, start_i = 0, rnd_valid_i = 0, out_ready_i = 0;
  logic [2:0] mode_i = 0;
  logic [8:0] len_i = 0;
  logic [31:0] rnd_data_i = 0;
  logic rnd_ready_o, out_valid_o, busy_o, done_o;
  logic [31:0] in_1_o, in_2_o;
`ifdef BINOM_FEED_STATS_EN
  logic [15:0] rnd_words_o;
`endif
  binom_feeder dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .len_i(len_i),
    .rnd_data_i(rnd_data_i), .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o),
    .in_1_o(in_1_o), .in_2_o(in_2_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o)
`ifdef BINOM_FEED_STATS_EN
    , .rnd_words_o(rnd_words_o)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int vpct = 100, rpct = 100;
  int words_acc = 0, beats_seen = 0, done_cnt = 0, cyc = 0, done_cyc = 0, last_pop_cyc = 0;
  logic [31:0] word_q[$], exp1_q[$], exp2_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int kof(input logic [2:0] m);
    return m == 0 ? 2 : m == 1 ? 3 : m == 2 ? 4 : m == 3 ? 5 : 8;
  endfunction
  function automatic int nwords(input int k, input int len);
    return (len * 4 * k + 31) / 32;
  endfunction
  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) word_q.push_back($urandom);
  endtask
  // reference: queued words form one LSB-first bit stream; each beat takes four k-bit fields
  task automatic model(input int k, input int len);
    bit s[$];
    logic [15:0] f[4];
    foreach (word_q[i]) for (int b = 0; b < 32; b++) s.push_back(word_q[i][b]);
    for (int j = 0; j < len; j++) begin
      for (int i = 0; i < 4; i++) begin
        f[i] = '0;
        for (int b = 0; b < k; b++) f[i][b] = s.pop_front();
      end
      exp1_q.push_back({f[2], f[0]});
      exp2_q.push_back({f[3], f[1]});
    end
  endtask
  // random-stream driver and output-ready generator
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = rnd_valid_i && rnd_ready_o;
      @(posedge clk);
      #1;
      if (acc && rst_n && word_q.size() > 0) begin
        word_q.delete(0);
        words_acc++;
      end
      rnd_valid_i = word_q.size() > 0 && $urandom_range(99) < vpct;
      rnd_data_i = rnd_valid_i ? word_q[0] : $urandom;
      out_ready_i = $urandom_range(99) < rpct;
    end
  end
  // monitor: pops expected beats on each handshake, checks stall stability and done pulses
  initial begin
    bit stall = 0;
    logic [31:0] p1 = 0, p2 = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) stall = 0;
      else begin
        if (stall) begin
          check("stall_valid", {31'd0, out_valid_o}, 32'd1);
          check("stall_in1", in_1_o, p1);
          check("stall_in2", in_2_o, p2);
        end
        if (out_valid_o && out_ready_i) begin
          beats_seen++;
          last_pop_cyc = cyc;
          if (exp1_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_beat: got in_1 %h in_2 %h expected no beat", in_1_o, in_2_o);
          end else begin
            check("beat_in1", in_1_o, exp1_q.pop_front());
            check("beat_in2", in_2_o, exp2_q.pop_front());
          end
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        stall = out_valid_o && !out_ready_i;
        p1 = in_1_o;
        p2 = in_2_o;
      end
    end
  end
  task automatic pulse_start(input logic [2:0] m, input int len);
    @(posedge clk);
    #1;
    mode_i = m;
    len_i = 9'(len);
    start_i = 1;
    @(posedge clk);
    #1;
    start_i = 0;
    mode_i = 3'($urandom);
    len_i = 9'($urandom);
  endtask
  task automatic run_job(input logic [2:0] m, input int len, input int vp, input int rp);
    int t = 0, ew;
    ew = word_q.size();
    vpct = vp;
    rpct = rp;
    words_acc = 0;
    beats_seen = 0;
    done_cnt = 0;
    model(kof(m), len);
    pulse_start(m, len);
`ifdef BINOM_FEED_STATS_EN
    check("stats_clear", {16'd0, rnd_words_o}, 32'd0);
`endif
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_cnt, 1);
    repeat (2) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("done_after_last", done_cyc, last_pop_cyc + 1);
    check("words_acc", words_acc, ew);
    check("beats_left", exp1_q.size(), 0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
`ifdef BINOM_FEED_STATS_EN
    check("stats_words", {16'd0, rnd_words_o}, ew);
`endif
  endtask
  initial begin
    int t, bad, d_idx, d_n;
    #12;
    check("rst_ctrl", {28'd0, rnd_ready_o, out_valid_o, busy_o, done_o}, 32'd0);
    check("rst_in1", in_1_o, 32'd0);
    check("rst_in2", in_2_o, 32'd0);
    #5 rst_n = 1;
    word_q = '{32'hA5C3_0F81, 32'h1234_5678};
    run_job(3'b100, 2, 100, 100);
    word_q = '{32'hFFFF_FFFF, 32'h0000_0000};
    run_job(3'b000, 5, 100, 100);
    rand_words(2);
    run_job(3'b011, 3, 50, 50);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] m;
      int len;
      m = 3'($urandom);
      len = $urandom_range(1, 24);
      rand_words(nwords(kof(m), len));
      run_job(m, len, 70, 60);
    end
    rand_words(8);
    run_job(3'b010, 16, 80, 80);
    // zero-length job
    bad = 0;
    d_idx = -1;
    d_n = 0;
    @(posedge clk);
    #1;
    mode_i = 3'b010;
    len_i = 0;
    start_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_o || rnd_ready_o || out_valid_o) bad++;
      if (done_o) begin
        d_n++;
        d_idx = i;
      end
      if (i == 0) begin
        @(posedge clk);
        #1;
        start_i = 0;
      end
    end
    check("len0_activity", bad, 0);
    check("len0_done_count", d_n, 1);
    check("len0_done_latency", d_idx, 1);
    // reset in the middle of a job
    rand_words(4);
    vpct = 60;
    rpct = 70;
    beats_seen = 0;
    model(3, 10);
    pulse_start(3'b001, 10);
    t = 0;
    while (beats_seen < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("mid_beats", beats_seen, 3);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_ctrl", {28'd0, rnd_ready_o, out_valid_o, busy_o, done_o}, 32'd0);
    check("mid_rst_in1", in_1_o, 32'd0);
    check("mid_rst_in2", in_2_o, 32'd0);
    word_q.delete();
    exp1_q.delete();
    exp2_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rand_words(1);
    run_job(3'b001, 1, 100, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
